cbx_param_cfg: RTL and testbench
================================

CBX_PARAM_CFG -- requirements
Module: cbx_param_cfg

Interface
REQ-001 Parameter CHAN_W, default 10: tracks per direction.
REQ-002 Parameter NUM_IPIN, default 7: grid input pins served.
REQ-003 Parameter MUX_SIZE, default 4: inputs per ipin mux, even power of two >= 2; SEL_W = log2(MUX_SIZE).
REQ-004 prog_clk  in  1  single clock for all sequential logic.
REQ-005 pReset  in  1  asynchronous, active-low reset.
REQ-006 cfg_en  in  1  shift-enable for the configuration chain.
REQ-007 cfg_commit  in  1  single-cycle request to apply the shifted configuration.
REQ-008 ccff_head  in  1  serial configuration data in.
REQ-009 ccff_tail  out  1  serial configuration data out (last shadow bit).
REQ-010 chanx_left_in / chanx_right_in  in  CHAN_W  routing tracks.
REQ-011 chanx_left_out / chanx_right_out  out  CHAN_W  routing tracks.
REQ-012 ipin_out  out  NUM_IPIN  mux outputs to grid pins.
REQ-013 cfg_valid  out  1  an accepted configuration is active.
REQ-014 cfg_err  out  1  sticky; last commit rejected.

Function
REQ-015 The block SHALL drive chanx_right_out = chanx_left_in and chanx_left_out = chanx_right_in combinationally.
REQ-016 Mux input j of ipin k SHALL be track t = (k + (j>>1)*(CHAN_W/2)) mod CHAN_W, from chanx_left_in for even j and from chanx_right_in for odd j.
REQ-017 ipin_out[k] SHALL be mux input act_sel[k] while cfg_valid=1, and 0 while cfg_valid=0.
REQ-018 The shadow chain SHALL be TOTAL bits (NUM_IPIN*SEL_W, plus 1 with parity). On each cycle with cfg_en=1, ccff_head enters bit 0, each bit i moves to i+1, and ccff_tail = shadow[TOTAL-1].
REQ-019 Shadow bits [k*SEL_W +: SEL_W] SHALL form the select for ipin k, LSB at the lower index.
REQ-020 A bit counter SHALL clear on the first cycle of an enable burst (cfg_en rising), increment per shifted bit, and saturate at TOTAL+1.
REQ-021 FSM states:
- UNCFG: reset state.
- SHIFT: cfg_en=1.
- CHECK: one cycle.
- RUN: configuration applied.
REQ-022 FSM transitions:
- UNCFG/RUN -> SHIFT on cfg_en=1.
- SHIFT -> the prior resting state (UNCFG or RUN) on cfg_en=0.
- UNCFG/RUN -> CHECK on cfg_commit=1 with cfg_en=0.
- CHECK -> RUN on pass.
- CHECK -> the prior resting state on fail.
REQ-023 A check SHALL pass iff the counter equals TOTAL, plus the parity rule when enabled. On pass, act_sel SHALL load from shadow at the CHECK edge, cfg_valid SHALL be 1 and cfg_err SHALL be 0 from the following cycle.
REQ-024 Commit latency SHALL be 2 edges: sampled at edge N, new ipin selection visible after edge N+1.
REQ-025 A failed check SHALL leave act_sel and cfg_valid unchanged and set cfg_err.
REQ-026 cfg_commit during cfg_en=1 or in CHECK SHALL be ignored.
REQ-027 Shifting while in RUN SHALL NOT disturb act_sel or ipin_out.
REQ-028 cfg_err SHALL clear only on the next cfg_en rising edge or on reset.

Reset
REQ-029 pReset=0 SHALL asynchronously force:
- shadow, act_sel and counter to 0;
- FSM to UNCFG;
- cfg_valid and cfg_err to 0, so ipin_out = 0.
REQ-030 Reset asserted mid-shift or in CHECK SHALL discard the partial load. Release SHALL require a fresh full load and commit.

Configuration
REQ-031 Macro CBX_CFG_PARITY_EN defined: TOTAL SHALL include one extra parity bit at shadow[TOTAL-1]; the check SHALL additionally require even parity over all TOTAL bits.
REQ-032 Macro CBX_CFG_PARITY_EN undefined: no parity bit SHALL exist and only the count rule SHALL apply.

Verification
REQ-033 Reset with defaults -> ipin_out=0, cfg_valid=0, cfg_err=0, ccff_tail=0.
REQ-034 Shift exactly 14 bits selecting input 2 for all ipins, then commit -> cfg_valid=1 two edges later; ipin_out[0] follows chanx_left_in[5].
REQ-035 Shift 13 bits, then commit -> cfg_err=1, cfg_valid and ipin_out unchanged. The next cfg_en burst clears cfg_err.
REQ-036 While in RUN, shift new data without commit -> ipin_out unchanged. Commit afterwards -> new selection after 2 edges.
REQ-037 With CBX_CFG_PARITY_EN defined, load 15 bits with odd parity, then commit -> cfg_err=1. Reload with even parity and commit -> cfg_valid=1.
REQ-038 Assert pReset mid-shift, then release -> all outputs at reset values. cfg_commit without reloading -> cfg_err=1.

Source files
------------

// File: rtl/cbx_param_cfg_if.sv
// Configuration-chain bus for the connection box: serial load, commit request and status.
interface cbx_param_cfg_if;
  logic cfg_en;
  logic cfg_commit;
  logic ccff_head;
  logic ccff_tail;
  logic cfg_valid;
  logic cfg_err;

  modport master (
    output cfg_en, cfg_commit, ccff_head,
    input  ccff_tail, cfg_valid, cfg_err
  );

  modport slave (
    input  cfg_en, cfg_commit, ccff_head,
    output ccff_tail, cfg_valid, cfg_err
  );
endinterface

// File: rtl/cbx_param_cfg.sv
// Parameterised connection box with a shadow/active configuration chain and commit check.
// Optional feature: define CBX_CFG_PARITY_EN to append an even-parity bit to the chain.
module cbx_param_cfg #(
  parameter int CHAN_W   = 10,
  parameter int NUM_IPIN = 7,
  parameter int MUX_SIZE = 4
) (
  input  logic                prog_clk,
  input  logic                pReset,
  cbx_param_cfg_if.slave      cfg,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out
);

  localparam int SEL_W = $clog2(MUX_SIZE);
`ifdef CBX_CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SEL_BITS = NUM_IPIN * SEL_W;
  localparam int TOTAL    = SEL_BITS + PAR_W;
  localparam int CNT_W    = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);

  typedef enum logic [1:0] {UNCFG, SHIFT, CHECK, RUN} state_e;

  state_e              state_q, state_d, resting;
  logic [TOTAL-1:0]    shadow_q, shadow_d;
  logic [SEL_BITS-1:0] act_sel_q, act_sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                en_q;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                burst_start;
  logic                parity_ok;
  logic                check_pass;

  assign burst_start = cfg.cfg_en & ~en_q;

`ifdef CBX_CFG_PARITY_EN
  assign parity_ok = ~^shadow_q;
`else
  assign parity_ok = 1'b1;
`endif

  assign check_pass = (cnt_q == CNT_FULL) && parity_ok;

  // The chain shifts whenever enabled, independent of FSM state; the count restarts per burst.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (cfg.cfg_en) begin
      shadow_d = {shadow_q[TOTAL-2:0], cfg.ccff_head};
      if (burst_start) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // cfg_valid is only ever set by a passing check, so it also encodes the resting state.
  always_comb begin
    state_d   = state_q;
    act_sel_d = act_sel_q;
    valid_d   = valid_q;
    err_d     = err_q;
    resting   = valid_q ? RUN : UNCFG;
    if (burst_start) begin
      err_d = 1'b0;
    end
    case (state_q)
      UNCFG, RUN: begin
        if (cfg.cfg_en) begin
          state_d = SHIFT;
        end else if (cfg.cfg_commit) begin
          state_d = CHECK;
        end
      end
      SHIFT: begin
        if (!cfg.cfg_en) begin
          state_d = resting;
        end
      end
      CHECK: begin
        if (check_pass) begin
          act_sel_d = shadow_q[SEL_BITS-1:0];
          valid_d   = 1'b1;
          err_d     = 1'b0;
          state_d   = RUN;
        end else begin
          err_d   = 1'b1;
          state_d = resting;
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q   <= UNCFG;
      shadow_q  <= '0;
      act_sel_q <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      act_sel_q <= act_sel_d;
      cnt_q     <= cnt_d;
      en_q      <= cfg.cfg_en;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Even mux inputs tap the left track, odd ones the right; pairs step by half a channel.
  logic [MUX_SIZE-1:0] mux_in [NUM_IPIN];

  for (genvar gk = 0; gk < NUM_IPIN; gk++) begin : g_ipin
    for (genvar gj = 0; gj < MUX_SIZE; gj++) begin : g_in
      localparam int T = (gk + (gj / 2) * (CHAN_W / 2)) % CHAN_W;
      if (gj % 2 == 0) begin : g_left
        assign mux_in[gk][gj] = chanx_left_in[T];
      end else begin : g_right
        assign mux_in[gk][gj] = chanx_right_in[T];
      end
    end
  end

  always_comb begin
    ipin_out = '0;
    for (int k = 0; k < NUM_IPIN; k++) begin
      if (valid_q) begin
        ipin_out[k] = mux_in[k][act_sel_q[k*SEL_W +: SEL_W]];
      end
    end
  end

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;

  assign cfg.ccff_tail = shadow_q[TOTAL-1];
  assign cfg.cfg_valid = valid_q;
  assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Randomised bench for cbx_param_cfg against a transaction-level model of loads and commits.
// Adapts the chain length when CBX_CFG_PARITY_EN is defined.
module tb_cbx_param_cfg;

  localparam int CHAN_W   = 10;
  localparam int NUM_IPIN = 7;
  localparam int MUX_SIZE = 4;
  localparam int SEL_W    = 2;
`ifdef CBX_CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int TOTAL = NUM_IPIN * SEL_W + PAR_W;

  logic                prog_clk = 1'b0;
  logic                pReset;
  logic [CHAN_W-1:0]   leftIn, rightIn, leftOut, rightOut;
  logic [NUM_IPIN-1:0] ipinOut;

  cbx_param_cfg_if cfgBus();

  cbx_param_cfg #(
    .CHAN_W  (CHAN_W),
    .NUM_IPIN(NUM_IPIN),
    .MUX_SIZE(MUX_SIZE)
  ) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .cfg            (cfgBus),
    .chanx_left_in  (leftIn),
    .chanx_right_in (rightIn),
    .chanx_left_out (leftOut),
    .chanx_right_out(rightOut),
    .ipin_out       (ipinOut)
  );

  always #5 prog_clk = ~prog_clk;

  int          checkCount = 0;
  int          failCount  = 0;
  bit          hist[$];
  int          burstLen;
  int          modelSel[NUM_IPIN];
  bit          modelValid;
  bit          modelErr;
  int          wantSel[NUM_IPIN];
  logic [63:0] loadImg;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Shadow bit i holds whatever was shifted in i shifts ago, or zero since reset.
  function automatic bit shadowBit(input int i);
    if (hist.size() > i) return hist[hist.size() - 1 - i];
    return 1'b0;
  endfunction

  function automatic logic [NUM_IPIN-1:0] expIpin();
    logic [NUM_IPIN-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_IPIN; k++) begin
      int j, t;
      j = modelSel[k];
      t = (k + (j / 2) * (CHAN_W / 2)) % CHAN_W;
      if (modelValid) r[k] = (j % 2 == 1) ? rightIn[t] : leftIn[t];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    @(negedge prog_clk);
  endtask

  task automatic randomChan();
    leftIn  = CHAN_W'($urandom);
    rightIn = CHAN_W'($urandom);
  endtask

  task automatic checkAll(input string tag);
    randomChan();
    #1;
    checkOutput({tag, "_ipin"},  32'(ipinOut), 32'(expIpin()));
    checkOutput({tag, "_valid"}, 32'(cfgBus.cfg_valid), 32'(modelValid));
    checkOutput({tag, "_err"},   32'(cfgBus.cfg_err), 32'(modelErr));
    checkOutput({tag, "_tail"},  32'(cfgBus.ccff_tail), 32'(shadowBit(TOTAL - 1)));
    checkOutput({tag, "_thru"},  32'({leftOut, rightOut}), 32'({rightIn, leftIn}));
  endtask

  task automatic buildImage(input bit badParity);
    bit p;
    loadImg = {$urandom, $urandom};
    for (int k = 0; k < NUM_IPIN; k++)
      for (int b = 0; b < SEL_W; b++)
        loadImg[k*SEL_W + b] = 1'((wantSel[k] >> b) & 1);
    p = 1'b0;
    for (int i = 0; i < TOTAL - PAR_W; i++) p = p ^ loadImg[i];
    if (PAR_W == 1) loadImg[TOTAL-1] = p ^ badParity;
  endtask

  task automatic randomSel();
    for (int k = 0; k < NUM_IPIN; k++) wantSel[k] = $urandom_range(MUX_SIZE - 1, 0);
  endtask

  // Shifts loadImg[n-1] first so a full burst lands image bit i at shadow index i.
  task automatic applyStimulus(input int n, input bit pokeCommit);
    for (int i = n - 1; i >= 0; i--) begin
      cfgBus.cfg_en     = 1'b1;
      cfgBus.ccff_head  = loadImg[i];
      cfgBus.cfg_commit = pokeCommit && (i == n / 2);
      tick();
      hist.push_back(loadImg[i]);
      modelErr = 1'b0;
      randomChan();
      #1;
      checkOutput("shift_ipin", 32'(ipinOut), 32'(expIpin()));
      if (i == n - 1) checkOutput("burst_err_clr", 32'(cfgBus.cfg_err), 32'(0));
    end
    cfgBus.cfg_en     = 1'b0;
    cfgBus.cfg_commit = 1'b0;
    cfgBus.ccff_head  = 1'b0;
    tick();
    burstLen = n;
    checkAll("after_shift");
  endtask

  task automatic commitCfg();
    bit pass, odd;
    odd = 1'b0;
    for (int i = 0; i < TOTAL; i++) odd = odd ^ shadowBit(i);
    pass = (burstLen == TOTAL) && !(PAR_W == 1 && odd);
    cfgBus.cfg_commit = 1'b1;
    tick();
    cfgBus.cfg_commit = 1'b0;
    checkAll("commit_edgeN");
    if (pass) begin
      for (int k = 0; k < NUM_IPIN; k++) begin
        modelSel[k] = 0;
        for (int b = 0; b < SEL_W; b++) modelSel[k] += int'(shadowBit(k*SEL_W + b)) << b;
      end
      modelValid = 1'b1;
      modelErr   = 1'b0;
    end else begin
      modelErr = 1'b1;
    end
    tick();
    checkAll("commit_edgeN1");
  endtask

  task automatic modelReset();
    hist.delete();
    burstLen   = 0;
    modelValid = 1'b0;
    modelErr   = 1'b0;
    for (int k = 0; k < NUM_IPIN; k++) modelSel[k] = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lens[5];
    pReset            = 1'b0;
    cfgBus.cfg_en     = 1'b0;
    cfgBus.cfg_commit = 1'b0;
    cfgBus.ccff_head  = 1'b0;
    randomChan();
    modelReset();
    @(negedge prog_clk);
    @(negedge prog_clk);
    checkAll("reset");
    pReset = 1'b1;
    tick();
    checkAll("idle");

    // Full load selecting input 2 everywhere: ipin 0 follows left track 5.
    for (int k = 0; k < NUM_IPIN; k++) wantSel[k] = 2;
    buildImage(1'b0);
    applyStimulus(TOTAL, 1'b0);
    commitCfg();
    randomChan();
    #1;
    checkOutput("ipin0_left5", 32'(ipinOut[0]), 32'(leftIn[5]));

    // Short load is rejected; next burst clears the error without touching the selection.
    randomSel();
    buildImage(1'b0);
    applyStimulus(TOTAL - 1, 1'b0);
    commitCfg();
    randomSel();
    buildImage(1'b0);
    applyStimulus(TOTAL, 1'b1);
    commitCfg();

    lens = '{TOTAL - 1, TOTAL, TOTAL, TOTAL + 1, TOTAL + 3};
    for (int it = 0; it < 10; it++) begin
      randomSel();
      buildImage((PAR_W == 1) && ($urandom_range(2, 0) == 0));
      applyStimulus(lens[$urandom_range(4, 0)], 1'($urandom_range(1, 0)));
      if ($urandom_range(3, 0) != 0) commitCfg();
    end

`ifdef CBX_CFG_PARITY_EN
    randomSel();
    buildImage(1'b1);
    applyStimulus(TOTAL, 1'b0);
    commitCfg();
    checkOutput("parity_bad_err", 32'(cfgBus.cfg_err), 32'(1));
    buildImage(1'b0);
    applyStimulus(TOTAL, 1'b0);
    commitCfg();
    checkOutput("parity_good_valid", 32'(cfgBus.cfg_valid), 32'(1));
`endif

    // Reset in the middle of a burst discards it; a bare commit afterwards must fail.
    randomSel();
    buildImage(1'b0);
    for (int i = 0; i < 5; i++) begin
      cfgBus.cfg_en    = 1'b1;
      cfgBus.ccff_head = loadImg[i];
      tick();
      hist.push_back(loadImg[i]);
      modelErr = 1'b0;
    end
    #2;
    pReset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_ipin",  32'(ipinOut), 32'(0));
    checkOutput("async_rst_valid", 32'(cfgBus.cfg_valid), 32'(0));
    checkOutput("async_rst_tail",  32'(cfgBus.ccff_tail), 32'(0));
    cfgBus.cfg_en    = 1'b0;
    cfgBus.ccff_head = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b1;
    tick();
    checkAll("post_reset");
    commitCfg();
    checkOutput("rst_commit_err", 32'(cfgBus.cfg_err), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
